// File: rtl/aui_pkg.sv
// Shared constants, block type and alignment-marker helper for the 1.6T AUI traffic source.
package aui_pkg;

  localparam int BITS_BLOCK   = 257;
  localparam int NUMBER_LANES = 16;
  localparam logic [27:0] AM_BASE = 28'hC168210;

  typedef logic [BITS_BLOCK-1:0] block_t;

  function automatic logic [31:0] am_marker(input logic [3:0] lane);
    return {AM_BASE, lane};
  endfunction

endpackage

// File: rtl/aui_am_block.sv
// Combinational alignment-marker block for one flow: header 0, eight 32-bit markers
// for PCS lanes 2k+flow (even lanes on flow 0, odd lanes on flow 1).
module aui_am_block
  import aui_pkg::*;
(
  input  logic   i_flow,
  output block_t o_block
);

  always_comb begin
    o_block = '0;
    for (int k = 0; k < NUMBER_LANES/2; k++) begin
      o_block[32*k+1 +: 32] = am_marker({k[2:0], i_flow});
    end
  end

endmodule

// File: rtl/aui_gen.sv
// 1.6T AUI traffic source: two 257-bit flows with a periodic AM block.
// Define AUI_PRBS_EN to take the data payload from a PRBS31 LFSR instead of the counter.
module aui_gen
  import aui_pkg::*;
#(
  parameter int AM_PERIOD = 16
) (
  input  logic         clk,
  input  logic         rst,
  output logic [3:0]   hexa_output,
  output logic [256:0] o_flow_0,
  output logic [256:0] o_flow_1
);

  localparam logic [15:0] POS_LAST = 16'(AM_PERIOD - 1);

  logic [15:0] r_pos;
  block_t      w_am_0;
  block_t      w_am_1;
  block_t      w_data_0;
  block_t      w_data_1;

  aui_am_block u_am_0 (.i_flow(1'b0), .o_block(w_am_0));
  aui_am_block u_am_1 (.i_flow(1'b1), .o_block(w_am_1));

`ifdef AUI_PRBS_EN
  logic [30:0]  r_lfsr;
  logic [30:0]  w_lfsr_next;
  logic [511:0] w_prbs;

  // Serial x^31+x^28+1 unrolled: 512 output bits, state advanced by 256 of them.
  always_comb begin
    logic [30:0] s;
    logic        fb;
    s      = r_lfsr;
    w_prbs = '0;
    for (int i = 0; i < 512; i++) begin
      fb        = s[30] ^ s[27];
      w_prbs[i] = fb;
      s         = {s[29:0], fb};
    end
    w_lfsr_next = '0;
    for (int j = 0; j < 31; j++) begin
      w_lfsr_next[j] = w_prbs[255-j];
    end
  end

  assign w_data_0 = {w_prbs[255:0],   1'b1};
  assign w_data_1 = {w_prbs[511:256], 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= '1;
    end else if (r_pos != '0) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  logic [63:0] r_d;

  assign w_data_0 = {r_d + 64'd3, r_d + 64'd2, r_d + 64'd1, r_d,         1'b1};
  assign w_data_1 = {r_d + 64'd7, r_d + 64'd6, r_d + 64'd5, r_d + 64'd4, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d <= '0;
    end else if (r_pos != '0) begin
      r_d <= r_d + 64'd8;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pos       <= '0;
      o_flow_0    <= '0;
      o_flow_1    <= '0;
      hexa_output <= '0;
    end else begin
      r_pos       <= (r_pos == POS_LAST) ? 16'd0 : r_pos + 16'd1;
      hexa_output <= r_pos[3:0];
      if (r_pos == '0) begin
        o_flow_0 <= w_am_0;
        o_flow_1 <= w_am_1;
      end else begin
        o_flow_0 <= w_data_0;
        o_flow_1 <= w_data_1;
      end
    end
  end

endmodule

// File: tb/tb_aui_gen.sv
// Directed self-checking bench for aui_gen (counter payload build, AM_PERIOD = 16).
module tb_aui_gen;

  localparam int AM_PERIOD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   hexa_output;
  logic [256:0] o_flow_0;
  logic [256:0] o_flow_1;

  int n_chk = 0;
  int n_bad = 0;

  aui_gen #(.AM_PERIOD(AM_PERIOD)) dut (
    .clk(clk),
    .rst(rst),
    .hexa_output(hexa_output),
    .o_flow_0(o_flow_0),
    .o_flow_1(o_flow_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [256:0] exp_am(input int f);
    logic [256:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      b[32*k+1 +: 32] = {28'hC168210, 4'(2*k + f)};
    end
    return b;
  endfunction

  function automatic logic [256:0] exp_data(input int f, input logic [63:0] d);
    logic [63:0] b;
    b = d + 64'(4*f);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b, 1'b1};
  endfunction

  task automatic chk_data(input string tag, input logic [63:0] d, input int pos);
    chk({tag, "_f0"}, o_flow_0, exp_data(0, d));
    chk({tag, "_f1"}, o_flow_1, exp_data(1, d));
    chk({tag, "_hex"}, 257'(hexa_output), 257'(pos[3:0]));
  endtask

  task automatic chk_am(input string tag);
    chk({tag, "_f0"}, o_flow_0, exp_am(0));
    chk({tag, "_f1"}, o_flow_1, exp_am(1));
    chk({tag, "_hex"}, 257'(hexa_output), 257'd0);
  endtask

  initial begin
    logic [63:0] d;

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_f0", o_flow_0, '0);
      chk("rst_f1", o_flow_1, '0);
      chk("rst_hex", 257'(hexa_output), 257'd0);
    end

    rst = 1'b1;
    tick();
    chk("am1_hdr", 257'(o_flow_0[0]), 257'd0);
    chk("am1_f0_m0", 257'(o_flow_0[32:1]), 257'(32'hC1682100));
    chk("am1_f1_m1", 257'(o_flow_1[32:1]), 257'(32'hC1682101));
    chk("am1_f1_m15", 257'(o_flow_1[256:225]), 257'(32'hC168210F));
    chk_am("am1");

    tick();
    chk("dat1_f0", o_flow_0, {64'd3, 64'd2, 64'd1, 64'd0, 1'b1});
    chk("dat1_f1", o_flow_1, {64'd7, 64'd6, 64'd5, 64'd4, 1'b1});
    chk("dat1_hex", 257'(hexa_output), 257'd1);

    d = 64'd8;
    for (int p = 2; p < AM_PERIOD; p++) begin
      tick();
      chk_data("dat", d, p);
      d = d + 64'd8;
    end

    tick();
    chk_am("am2");

    tick();
    chk("dat_p2_f0", o_flow_0, exp_data(0, 64'd120));
    chk_data("dat_p2", 64'd120, 1);
    tick();
    chk_data("dat_p2b", 64'd128, 2);
    tick();

    rst = 1'b0;
    tick();
    chk("mrst_f0", o_flow_0, '0);
    chk("mrst_f1", o_flow_1, '0);
    chk("mrst_hex", 257'(hexa_output), 257'd0);
    rst = 1'b1;
    tick();
    chk_am("am3");
    tick();
    chk_data("dat_r", 64'd0, 1);
    tick();
    chk_data("dat_r2", 64'd8, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
